// File: rtl/spi_master_multi.sv
// spi_master_multi: parametrised SPI master with configurable word width,
// SCLK divider, per-transfer CPOL/CPHA and bit order, and NUM_SS one-hot
// active-low slave selects. A transfer runs IDLE -> SETUP -> XFER -> HOLD.
// SETUP, each SCLK half-period and HOLD each last CLK_DIV clk cycles.
// All outputs come straight from registers.
module spi_master_multi #(
  parameter int DATA_W  = 8,
  parameter int NUM_SS  = 4,
  parameter int CLK_DIV = 4,
  localparam int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);

  localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Bit that goes on the wire next, given the current bit order.
  function automatic logic out_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  // Drop the bit just transmitted.
  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w,
                                                  input logic lsb);
    return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  // Insert a received bit so the first bit on the wire lands where it came from.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w,
                                                 input logic lsb, input logic b);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    div_cnt_r, div_cnt_s;
  logic [EDGE_W-1:0]   edge_cnt_r, edge_cnt_s;
  logic [DATA_W-1:0]   tx_sh_r, tx_sh_s;
  logic [DATA_W-1:0]   rx_sh_r, rx_sh_s;
  logic                cpol_r, cpol_s;
  logic                cpha_r, cpha_s;
  logic                lsb_r, lsb_s;
  logic                sclk_r, sclk_s;
  logic                mosi_r, mosi_s;
  logic [NUM_SS-1:0]   ss_n_r, ss_n_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic [DATA_W-1:0]   data_out_r, data_out_s;

  logic                tick_s;
  logic                ss_ok_s;
  logic [EDGE_W-1:0]   edge_num_s;

  assign tick_s     = (div_cnt_r == DIV_LAST);
  assign ss_ok_s    = (32'(ss_sel) < 32'(NUM_SS));
  assign edge_num_s = edge_cnt_r + EDGE_W'(1'b1);

  assign busy     = busy_r;
  assign done     = done_r;
  assign data_out = data_out_r;
  assign sclk     = sclk_r;
  assign mosi     = mosi_r;
  assign ss_n     = ss_n_r;

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_s    = state_r;
    div_cnt_s  = div_cnt_r;
    edge_cnt_s = edge_cnt_r;
    tx_sh_s    = tx_sh_r;
    rx_sh_s    = rx_sh_r;
    cpol_s     = cpol_r;
    cpha_s     = cpha_r;
    lsb_s      = lsb_r;
    sclk_s     = sclk_r;
    mosi_s     = mosi_r;
    ss_n_s     = ss_n_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    data_out_s = data_out_r;

    case (state_r)
      ST_IDLE: begin
        sclk_s     = cpol;
        div_cnt_s  = {CNT_W{1'b0}};
        edge_cnt_s = {EDGE_W{1'b0}};
        if (start && ss_ok_s) begin
          state_s = ST_SETUP;
          busy_s  = 1'b1;
          cpol_s  = cpol;
          cpha_s  = cpha;
          lsb_s   = lsb_first;
          rx_sh_s = {DATA_W{1'b0}};
          for (int i = 0; i < NUM_SS; i++) begin
            ss_n_s[i] = (SEL_W'(i) != ss_sel);
          end
          if (!cpha) begin
            // Leading-edge sampling: first bit must be on the wire before edge 1.
            mosi_s  = out_bit(data_in, lsb_first);
            tx_sh_s = shift_out(data_in, lsb_first);
          end else begin
            tx_sh_s = data_in;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SETUP, ST_XFER: begin
        if (tick_s) begin
          div_cnt_s  = {CNT_W{1'b0}};
          sclk_s     = ~sclk_r;
          edge_cnt_s = edge_num_s;
          // Odd edges are leading edges; cpha selects which parity samples.
          if (edge_num_s[0] != cpha_r) begin
            rx_sh_s = shift_in(rx_sh_r, lsb_r, miso);
          end else if (edge_num_s != EDGE_LAST) begin
            mosi_s  = out_bit(tx_sh_r, lsb_r);
            tx_sh_s = shift_out(tx_sh_r, lsb_r);
          end else begin
            tx_sh_s = tx_sh_r;
          end
          if (edge_num_s == EDGE_LAST) begin
            state_s = ST_HOLD;
          end else begin
            state_s = ST_XFER;
          end
        end else begin
          div_cnt_s = div_cnt_r + CNT_W'(1'b1);
        end
      end

      ST_HOLD: begin
        if (tick_s) begin
          div_cnt_s  = {CNT_W{1'b0}};
          state_s    = ST_IDLE;
          sclk_s     = cpol_r;
          ss_n_s     = {NUM_SS{1'b1}};
          busy_s     = 1'b0;
          done_s     = 1'b1;
          data_out_s = rx_sh_r;
        end else begin
          div_cnt_s = div_cnt_r + CNT_W'(1'b1);
        end
      end

      default: begin
        state_s = ST_IDLE;
        ss_n_s  = {NUM_SS{1'b1}};
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      div_cnt_r  <= {CNT_W{1'b0}};
      edge_cnt_r <= {EDGE_W{1'b0}};
      tx_sh_r    <= {DATA_W{1'b0}};
      rx_sh_r    <= {DATA_W{1'b0}};
      cpol_r     <= 1'b0;
      cpha_r     <= 1'b0;
      lsb_r      <= 1'b0;
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b0;
      ss_n_r     <= {NUM_SS{1'b1}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      data_out_r <= {DATA_W{1'b0}};
    end else begin
      state_r    <= state_s;
      div_cnt_r  <= div_cnt_s;
      edge_cnt_r <= edge_cnt_s;
      tx_sh_r    <= tx_sh_s;
      rx_sh_r    <= rx_sh_s;
      cpol_r     <= cpol_s;
      cpha_r     <= cpha_s;
      lsb_r      <= lsb_s;
      sclk_r     <= sclk_s;
      mosi_r     <= mosi_s;
      ss_n_r     <= ss_n_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      data_out_r <= data_out_s;
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: a default 8-bit/4-slave/div-4 instance and a
// 16-bit/1-slave/div-1 instance. Expected words and done cycles are queued
// when a transfer is launched and checked when done pulses.
module tb_spi_master_multi;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t e0, e1;

  // ---------------- instance 0: defaults ----------------
  logic       start0 = 1'b0;
  logic [7:0] data_in0 = 8'h00;
  logic [1:0] ss_sel0 = 2'd0;
  logic       cpol0 = 1'b0, cpha0 = 1'b0, lsb0 = 1'b0;
  logic       busy0, done0, sclk0, mosi0, miso0;
  logic [7:0] data_out0;
  logic [3:0] ss_n0;

  logic       loop_en = 1'b1;
  logic       slave_miso = 1'b0;
  logic [7:0] slave_word = 8'h00;
  logic [7:0] slv_tx = 8'h00;
  logic [7:0] slv_rx = 8'h00;

  assign miso0 = loop_en ? mosi0 : slave_miso;

  spi_master_multi u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .data_in(data_in0),
    .ss_sel(ss_sel0), .cpol(cpol0), .cpha(cpha0), .lsb_first(lsb0),
    .busy(busy0), .done(done0), .data_out(data_out0), .sclk(sclk0),
    .mosi(mosi0), .miso(miso0), .ss_n(ss_n0)
  );

  // Mode-3, MSB-first slave on select 0: drives on falling, samples on rising.
  always @(negedge ss_n0[0]) begin
    slv_tx <= slave_word;
    slv_rx <= 8'h00;
  end
  always @(negedge sclk0) begin
    if (!ss_n0[0]) begin
      slave_miso <= slv_tx[7];
      slv_tx     <= {slv_tx[6:0], 1'b0};
    end
  end
  always @(posedge sclk0) begin
    if (!ss_n0[0]) slv_rx <= {slv_rx[6:0], mosi0};
  end

  // ---------------- instance 1: 16-bit, div 1, one slave ----------------
  logic        start1 = 1'b0;
  logic [15:0] data_in1 = 16'h0000;
  logic [0:0]  ss_sel1 = 1'b0;
  logic        cpol1 = 1'b0, cpha1 = 1'b0, lsb1 = 1'b0;
  logic        busy1, done1, sclk1, mosi1, miso1;
  logic [15:0] data_out1;
  logic [0:0]  ss_n1;

  assign miso1 = mosi1;

  spi_master_multi #(.DATA_W(16), .NUM_SS(1), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .data_in(data_in1),
    .ss_sel(ss_sel1), .cpol(cpol1), .cpha(cpha1), .lsb_first(lsb1),
    .busy(busy1), .done(done1), .data_out(data_out1), .sclk(sclk1),
    .mosi(mosi1), .miso(miso1), .ss_n(ss_n1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for instance 0.
  always @(negedge clk) begin
    if (rst_n && done0) begin
      if (sb0.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL done0_spurious: got done at cycle %0d, required none", cyc);
      end else begin
        e0 = sb0.pop_front();
        chk("data_out0", 32'(data_out0), 32'(e0.data));
        chk("done0_cycle", 32'(cyc), 32'(e0.cyc));
      end
    end
  end

  // Scoreboard for instance 1.
  always @(negedge clk) begin
    if (rst_n && done1) begin
      if (sb1.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL done1_spurious: got done at cycle %0d, required none", cyc);
      end else begin
        e1 = sb1.pop_front();
        chk("data_out1", 32'(data_out1), 32'(e1.data));
        chk("done1_cycle", 32'(cyc), 32'(e1.cyc));
      end
    end
  end

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic       lsb;
    logic       loop;
    logic       intrude;
    logic [7:0] din;
    logic [1:0] sel;
    logic [7:0] slv;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    exp_t       e;
    logic [3:0] exp_ss;
    logic       fb;
    logic       prev;
    int         toggles;
    int         ssbad;
    bit         seen;
    exp_ss  = 4'hF;
    exp_ss[v.sel] = 1'b0;
    fb      = v.lsb ? v.din[0] : v.din[7];
    toggles = 0;
    ssbad   = 0;
    seen    = 1'b0;

    cpol0 = v.cpol; cpha0 = v.cpha; lsb0 = v.lsb;
    loop_en = v.loop; slave_word = v.slv;
    step();
    chk("idle_sclk", 32'(sclk0), 32'(v.cpol));

    data_in0 = v.din; ss_sel0 = v.sel; start0 = 1'b1;
    e.data = 16'(v.exp);
    e.cyc  = cyc + 69;
    sb0.push_back(e);
    step();
    start0 = 1'b0;
    data_in0 = ~v.din; ss_sel0 = v.sel + 2'd1; cpha0 = ~v.cpha; lsb0 = ~v.lsb;
    chk("busy_on", 32'(busy0), 32'd1);
    chk("ss_n_sel", 32'(ss_n0), 32'(exp_ss));
    if (!v.cpha) chk("first_mosi_cpha0", 32'(mosi0), 32'(fb));
    prev = sclk0;

    for (int k = 2; k <= 100 && !seen; k++) begin
      step();
      if (k == 10 && v.intrude) begin
        start0 = 1'b1; ss_sel0 = 2'd3; data_in0 = 8'hFF;
      end
      if (k == 11) start0 = 1'b0;
      if (sclk0 != prev) toggles++;
      prev = sclk0;
      if (v.cpha && k == 5) chk("first_mosi_cpha1", 32'(mosi0), 32'(fb));
      if (done0) seen = 1'b1;
      else if (ss_n0 != exp_ss || !busy0) ssbad++;
    end

    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL done0_timeout: got no done in 100 cycles, required done at +69");
    end else begin
      chk("sclk_edges", 32'(toggles), 32'd16);
      chk("ss_busy_stable", 32'(ssbad), 32'd0);
      chk("busy_off", 32'(busy0), 32'd0);
      chk("ss_n_release", 32'(ss_n0), 32'hF);
      chk("end_sclk", 32'(sclk0), 32'(v.cpol));
      if (!v.loop) chk("slave_rx", 32'(slv_rx), 32'(v.din));
    end
    step();
    chk("done_pulse", 32'(done0), 32'd0);
  endtask

  task automatic reset_abort();
    int dcnt;
    dcnt = 0;
    cpol0 = 1'b0; cpha0 = 1'b0; lsb0 = 1'b0; loop_en = 1'b1;
    step();
    data_in0 = 8'h5A; ss_sel0 = 2'd1; start0 = 1'b1;
    step();
    start0 = 1'b0;
    repeat (29) step();
    rst_n = 1'b0;
    #1;
    chk("abort_ss_n", 32'(ss_n0), 32'hF);
    chk("abort_sclk", 32'(sclk0), 32'd0);
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step();
      if (done0) dcnt++;
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);
    chk("abort_idle_busy", 32'(busy0), 32'd0);
  endtask

  task automatic run16(input logic [15:0] din, input logic pol, input logic pha,
                       input logic lsb);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    cpol1 = pol; cpha1 = pha; lsb1 = lsb;
    step();
    data_in1 = din; ss_sel1 = 1'b0; start1 = 1'b1;
    e.data = din;
    e.cyc  = cyc + 34;
    sb1.push_back(e);
    step();
    start1 = 1'b0; data_in1 = ~din;
    chk("busy1_on", 32'(busy1), 32'd1);
    chk("ss_n1_low", 32'(ss_n1), 32'd0);
    for (int k = 2; k <= 60 && !seen; k++) begin
      step();
      if (done1) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL done1_timeout: got no done in 60 cycles, required done at +34");
    end else begin
      chk("busy1_off", 32'(busy1), 32'd0);
      chk("ss_n1_high", 32'(ss_n1), 32'd1);
      chk("sclk1_idle", 32'(sclk1), 32'(pol));
    end
    step();
    chk("done1_pulse", 32'(done1), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 2'd0, 8'h00, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC3, 2'd0, 8'h3C, 8'h3C};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 2'd2, 8'h00, 8'h01};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 2'd0, 8'h00, 8'hA5};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 2'd1, 8'h00, 8'h5A};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h96, 2'd3, 8'h00, 8'h96};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 2'd2, 8'h00, 8'h3C};

    rst_n = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_ss_n", 32'(ss_n0), 32'hF);
    chk("rst_sclk", 32'(sclk0), 32'd0);
    chk("rst_mosi", 32'(mosi0), 32'd0);
    chk("rst_data_out", 32'(data_out0), 32'd0);
    chk("rst_data_out1", 32'(data_out1), 32'd0);
    chk("rst_ss_n1", 32'(ss_n1), 32'd1);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    reset_abort();
    run_vec(vecs[0]);

    // Out-of-range select on the single-slave instance is ignored.
    cpol1 = 1'b0;
    step();
    data_in1 = 16'hFFFF; ss_sel1 = 1'b1; start1 = 1'b1;
    step();
    start1 = 1'b0; ss_sel1 = 1'b0;
    chk("sel_oob_busy", 32'(busy1), 32'd0);
    chk("sel_oob_ss_n", 32'(ss_n1), 32'd1);
    step();
    step();
    chk("sel_oob_busy_later", 32'(busy1), 32'd0);

    run16(16'hBEEF, 1'b0, 1'b0, 1'b0);
    run16(16'h1234, 1'b1, 1'b1, 1'b1);
    run16(16'h8001, 1'b0, 1'b1, 1'b0);

    repeat (5) step();
    chk("sb0_drained", 32'(sb0.size()), 32'd0);
    chk("sb1_drained", 32'(sb1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
